// File: rtl/ghost_mover_if.sv
// ghost_mover_if: movement strobe, direction request, wall flags and position/heading outputs of one ghost.
interface ghost_mover_if #(
    parameter int X_W  = 5,
    parameter int Y_W  = 5,
    parameter int SS_W = 2
);
    logic            moveTick;
    logic [1:0]      dirToMove;
    logic            canMoveU;
    logic            canMoveR;
    logic            canMoveD;
    logic            canMoveL;
    logic            eaten;
    logic [X_W-1:0]  ghostPosX;
    logic [Y_W-1:0]  ghostPosY;
    logic [SS_W-1:0] subStep;
    logic [1:0]      curDir;
    logic            moving;
    logic            inHouse;
    modport master (
        output moveTick, dirToMove, canMoveU, canMoveR, canMoveD, canMoveL, eaten,
        input  ghostPosX, ghostPosY, subStep, curDir, moving, inHouse
    );
    modport slave (
        input  moveTick, dirToMove, canMoveU, canMoveR, canMoveD, canMoveL, eaten,
        output ghostPosX, ghostPosY, subStep, curDir, moving, inHouse
    );
endinterface

// File: rtl/ghost_mover.sv
// ghost_mover: ghost tile position/heading FSM with house hold, respawn when eaten and tunnel wrap.
// Define GHOST_MOVER_TUNNEL_SLOW_EN to halve movement speed inside the tunnel columns.
module ghost_mover #(
    parameter int X_W            = 5,
    parameter int Y_W            = 5,
    parameter int MAZE_W         = 28,
    parameter int START_X        = 13,
    parameter int START_Y        = 11,
    parameter int STEPS_PER_TILE = 4,
    parameter int HOUSE_WAIT     = 8,
    parameter int TUNNEL_Y       = 14,
    parameter int TUNNEL_EDGE    = 6
) (
    input logic         clk,
    input logic         reset,
    ghost_mover_if.slave bus
);
    localparam int SS_W = $clog2(STEPS_PER_TILE);
    localparam int HC_W = $clog2(HOUSE_WAIT + 1);
    localparam logic [X_W-1:0]  MAX_X = X_W'(MAZE_W - 1);
    localparam logic [SS_W-1:0] LAST  = SS_W'(STEPS_PER_TILE - 1);

    typedef enum logic [1:0] {HOLD, IDLE, STEP} state_t;

    state_t          state_q, state_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic [SS_W-1:0] sub_q, sub_d;
    logic [1:0]      dir_q, dir_d;
    logic [3:0]      can;
    logic [1:0]      cand;
    logic            tick;

    assign can  = {bus.canMoveL, bus.canMoveD, bus.canMoveR, bus.canMoveU};
    assign cand = (bus.dirToMove == (dir_q ^ 2'b10)) ? dir_q : bus.dirToMove;

`ifdef GHOST_MOVER_TUNNEL_SLOW_EN
    logic in_tun, tog_q, tog_d;
    assign in_tun = (y_q == Y_W'(TUNNEL_Y)) &&
                    ((x_q < X_W'(TUNNEL_EDGE)) || (x_q >= X_W'(MAZE_W - TUNNEL_EDGE)));
    // only the second of each pair of ticks acts while inside the tunnel
    assign tick  = bus.moveTick && (!in_tun || tog_q);
    assign tog_d = !bus.eaten && in_tun && (tog_q ^ bus.moveTick);
    always_ff @(posedge clk or posedge reset)
        if (reset) tog_q <= 1'b0;
        else       tog_q <= tog_d;
`else
    assign tick = bus.moveTick;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        x_d     = x_q;
        y_d     = y_q;
        sub_d   = sub_q;
        dir_d   = dir_q;
        if (bus.eaten) begin
            state_d = HOLD;
            hold_d  = HC_W'(HOUSE_WAIT);
            x_d     = X_W'(START_X);
            y_d     = Y_W'(START_Y);
            sub_d   = '0;
            dir_d   = 2'b00;
        end else if (tick) begin
            case (state_q)
                HOLD: begin
                    hold_d  = hold_q - HC_W'(1);
                    state_d = (hold_q == HC_W'(1)) ? IDLE : HOLD;
                end
                IDLE: if (can[cand] || can[dir_q]) begin
                    dir_d   = can[cand] ? cand : dir_q;
                    sub_d   = SS_W'(1);
                    state_d = STEP;
                end
                default: begin
                    sub_d = sub_q + SS_W'(1);
                    if (sub_q == LAST) begin
                        state_d = IDLE;
                        x_d = (dir_q == 2'b01) ? ((x_q == MAX_X) ? '0 : x_q + X_W'(1)) :
                              (dir_q == 2'b11) ? ((x_q == '0) ? MAX_X : x_q - X_W'(1)) : x_q;
                        y_d = (dir_q == 2'b00) ? y_q - Y_W'(1) :
                              (dir_q == 2'b10) ? y_q + Y_W'(1) : y_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HOLD;
            hold_q  <= HC_W'(HOUSE_WAIT);
            x_q     <= X_W'(START_X);
            y_q     <= Y_W'(START_Y);
            sub_q   <= '0;
            dir_q   <= 2'b11;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sub_q   <= sub_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.ghostPosX = x_q;
    assign bus.ghostPosY = y_q;
    assign bus.subStep   = sub_q;
    assign bus.curDir    = dir_q;
    assign bus.moving    = (state_q == STEP);
    assign bus.inHouse   = (state_q == HOLD);
endmodule

// File: doc/ghost_mover.md
Name: ghost_mover

Overview:
- Downstream stage of each ghost's behaviour/direction-select logic.
- Consumes the 2-bit dirToMove plus the canMove flags. Owns the ghost's tile position, sub-tile step counter and current heading.
- Its ghostPosX/ghostPosY outputs feed back into the behaviour block's distance/target math and into the renderer.
- Also handles ghost-house hold/release, re-spawn on being eaten, and horizontal tunnel wrap-around.

Parameters:
- X_W, 5, width of X tile coordinate
- Y_W, 5, width of Y tile coordinate
- MAZE_W, 28, maze width in tiles (X range 0..MAZE_W-1)
- START_X, 13, spawn/house X tile
- START_Y, 11, spawn/house Y tile
- STEPS_PER_TILE, 4, moveTicks per tile traversal (power of two, >=2)
- HOUSE_WAIT, 8, moveTicks held in house after reset/eaten (>=1)
- TUNNEL_Y, 14, row containing the wrap tunnel
- TUNNEL_EDGE, 6, tunnel columns: X<TUNNEL_EDGE or X>=MAZE_W-TUNNEL_EDGE

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- moveTick  in  1  single-cycle movement strobe from the game timer
- dirToMove  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- canMoveU/canMoveR/canMoveD/canMoveL  in  1 each  wall-check flags for the tile the ghost currently occupies
- eaten  in  1  single-cycle pulse: ghost was eaten by pacman
- ghostPosX  out  X_W  current tile X
- ghostPosY  out  Y_W  current tile Y
- subStep  out  $clog2(STEPS_PER_TILE)  progress into the next tile
- curDir  out  2  current heading
- moving  out  1  high while in STEP
- inHouse  out  1  high while in HOLD

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state is registered, so outputs change only on the clk edge.
- Reset values:
  - state=HOLD, holdCnt=HOUSE_WAIT
  - ghostPosX=START_X, ghostPosY=START_Y
  - subStep=0, curDir=11 (left), moving=0, inHouse=1
- State HOLD:
  - Each moveTick decrements holdCnt.
  - The tick that takes holdCnt from 1 to 0 moves the state to IDLE. inHouse falls the following cycle.
  - dirToMove is ignored.
- State IDLE (tile-aligned, subStep=0). On moveTick the direction is chosen as follows:
  - Candidate = dirToMove, unless it is the exact reverse of curDir, in which case candidate = curDir.
  - If canMove[candidate]=1: curDir<=candidate, subStep<=1, go to STEP.
  - Else if canMove[curDir]=1: keep curDir, subStep<=1, go to STEP.
  - Else stay in IDLE with no change; moving stays 0.
  - Without moveTick, nothing changes.
- State STEP:
  - Each moveTick increments subStep. canMove and dirToMove are ignored mid-tile.
  - On the tick where subStep==STEPS_PER_TILE-1: subStep<=0, the position advances one tile in curDir, and the state returns to IDLE in that same cycle.
  - Position change latency is therefore exactly STEPS_PER_TILE moveTicks from departure.
- Arithmetic:
  - Up: Y-1. Down: Y+1. Right: X+1. Left: X-1.
  - X wraps: right from MAZE_W-1 gives 0; left from 0 gives MAZE_W-1.
  - Y never wraps. Walls guarantee this; no check is performed.
- eaten:
  - Accepted in any state, with priority over a simultaneous moveTick.
  - Next cycle: state=HOLD, holdCnt=HOUSE_WAIT, position=START, subStep=0, curDir=00, inHouse=1, moving=0.
  - eaten while already in HOLD reloads holdCnt.
- Reset asserted mid-step aborts immediately to the reset values above.
- moving = (state==STEP). inHouse = (state==HOLD).

Optional Feature:
- Macro: GHOST_MOVER_TUNNEL_SLOW_EN.
- Defined: while ghostPosY==TUNNEL_Y and ghostPosX is in the tunnel columns, a 1-bit toggle gates moveTick. Only every second moveTick acts, in IDLE and STEP alike (half speed). The toggle clears on reset, on eaten, and on leaving the tunnel region.
- Undefined: tunnel tiles are traversed at full speed; no toggle register exists.

Test Plan:
- Reset release, moveTick every 4 clks: inHouse stays 1 through 7 ticks. After the 8th tick the state is IDLE, inHouse=0, pos=(13,11), curDir=11.
- IDLE at (13,11), curDir=11, dirToMove=01 (reverse), canMoveL=1: ghost moves left. After 4 ticks, subStep sequence is 1,2,3,0 and pos=(12,11).
- IDLE at (13,11), curDir=01, dirToMove=00, canMoveU=1: curDir=00. After 4 ticks pos=(13,10).
- dirToMove=00, canMoveU=0, canMoveR=1, curDir=01: continues right. With all canMove=0: stays IDLE, moving=0, pos unchanged over 10 ticks.
- Tunnel wrap, macro off: pos=(1,14), curDir=11, canMoveL=1 held. After 4 ticks pos=(0,14); after 8 ticks pos=(27,14).
- Macro on: same tunnel stimulus needs 8 ticks per tile. Separately, eaten together with moveTick at subStep=2: next cycle pos=(13,11), subStep=0, curDir=00, inHouse=1; release after 8 further ticks.
